ps2_scancode_decoder: RTL and testbench
=======================================

// Module: ps2_scancode_decoder
// PURPOSE
//   Consumes the byte stream from PS2_Controller (received_data/received_data_en) and decodes
//   PS/2 scan-code set 2 into key events {extended, release, code}. Events are buffered in a
//   FWFT FIFO and drained via a valid/ready handshake. Tracks modifier key state.
//   Sits between PS2_Controller and the keyboard-input logic of the LALU-2.0 system.
// PARAMETERS
//   FIFO_DEPTH  8   event FIFO entries; power of two, >=2
//   FIFO_AW     3   log2(FIFO_DEPTH); must match FIFO_DEPTH
// PORTS
//   CLOCK_50       in   1   system clock, 50 MHz
//   reset          in   1   asynchronous reset, active-high
//   rx_data        in   8   byte from PS2_Controller.received_data
//   rx_en          in   1   1-cycle strobe, rx_data valid (PS2_Controller.received_data_en)
//   ev_valid       out  1   FIFO non-empty; ev_* hold head entry
//   ev_ready       in   1   consumer pops head when ev_valid & ev_ready
//   ev_code        out  8   head scan code (8'hE1 = Pause)
//   ev_ext         out  1   head code was E0-prefixed
//   ev_rel         out  1   head is a break (release) event
//   ev_count       out  FIFO_AW+1  entries currently stored
//   overflow       out  1   sticky: an event was dropped because the FIFO was full
//   ovf_clr        in   1   synchronous clear of overflow
//   mod_shift      out  1   L-Shift(12) or R-Shift(59) held
//   mod_ctrl       out  1   L-Ctrl(14) or R-Ctrl(E0 14) held
//   mod_alt        out  1   L-Alt(11) or R-Alt(E0 11) held
// BEHAVIOUR
//   Reset (async, all regs): state=IDLE, FIFO empty, ev_valid=0, ev_count=0, ev_code/ev_ext/ev_rel=0,
//   overflow=0, all mod_*=0, skip counter=0. Reset mid-sequence discards the partial code.
//   Bytes are sampled only when rx_en=1; rx_data is ignored otherwise.
//   Parser FSM (one transition per rx_en):
//     IDLE:  E0->EXT; F0->BRK; E1->PAUSE (cnt=7); AA,FA,EE,FE,00,FF -> dropped, stay IDLE;
//            other -> push {ext=0,rel=0,code}, IDLE
//     EXT:   F0->EXTBRK; E0/E1/F0-class -> IDLE, no push (protocol error); other -> push {1,0,code}, IDLE
//     BRK:   any -> push {0,1,code}, IDLE
//     EXTBRK:any -> push {1,1,code}, IDLE
//     PAUSE: cnt decrements per byte; when cnt reaches 0 -> push {0,0,8'hE1}, IDLE
//   E0 12 / E0 F0 12 (fake shift around PrtScr) are dropped, not pushed.
//   Modifier flags update in the same cycle as the push of the matching make/break event,
//   regardless of whether the FIFO accepted the push.
//   Push latency: event visible on ev_* with ev_valid=1 one cycle after the final byte's rx_en.
//   FIFO: FWFT, ev_* combinational from head; pop on ev_valid & ev_ready.
//     Push+pop same cycle: both performed, count unchanged, even when full.
//     Push when full without pop: event dropped, overflow<=1. Pop when empty: ignored.
//     Pointers wrap modulo FIFO_DEPTH. ovf_clr and a new overflow in same cycle: overflow stays 1.
//   ev_* undefined-but-stable when ev_valid=0 (drive last head value).
// TESTING
//   rx 1C -> next cycle ev_valid=1, ev_code=1C, ev_ext=0, ev_rel=0; ev_ready=1 -> ev_count=0.
//   rx E0 F0 75 -> single event {ext=1,rel=1,code=75}; no event after E0 or F0 alone.
//   rx E1 14 77 E1 F0 14 F0 77 -> exactly one event code=E1; no others; state IDLE afterwards.
//   ev_ready=0, send 9 make codes (depth 8) -> ev_count=8, overflow=1, head=first code; ovf_clr -> 0.
//   full FIFO, push and pop same cycle -> ev_count stays 8, overflow stays 0, new code at tail.
//   rx 12 -> mod_shift=1; E0 14 -> mod_ctrl=1; F0 12 -> mod_shift=0; reset after E0 -> next 1C gives ext=0.

Source files
------------

// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / event-out bundle for the PS/2 scan-code decoder.
// The slave side is the decoder; the master side feeds bytes and drains events.
interface ps2_scancode_decoder_if #(
  parameter int unsigned FIFO_AW = 3
) ();
  logic [7:0]       rx_data;
  logic             rx_en;
  logic             ev_valid;
  logic             ev_ready;
  logic [7:0]       ev_code;
  logic             ev_ext;
  logic             ev_rel;
  logic [FIFO_AW:0] ev_count;
  logic             overflow;
  logic             ovf_clr;
  logic             mod_shift;
  logic             mod_ctrl;
  logic             mod_alt;

  modport master (
    output rx_data, rx_en, ev_ready, ovf_clr,
    input  ev_valid, ev_code, ev_ext, ev_rel, ev_count, overflow,
           mod_shift, mod_ctrl, mod_alt
  );

  modport slave (
    input  rx_data, rx_en, ev_ready, ovf_clr,
    output ev_valid, ev_code, ev_ext, ev_rel, ev_count, overflow,
           mod_shift, mod_ctrl, mod_alt
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code set 2 decoder: turns the PS2_Controller byte stream into
// {ext, rel, code} key events queued in a first-word-fall-through FIFO.
module ps2_scancode_decoder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_AW    = 3
) (
  input logic                   CLOCK_50,
  input logic                   reset,
  ps2_scancode_decoder_if.slave bus
);

  localparam int unsigned CW = FIFO_AW + 1;
  localparam int unsigned EW = 10;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] EXT    = 3'd1;
  localparam logic [2:0] BRK    = 3'd2;
  localparam logic [2:0] EXTBRK = 3'd3;
  localparam logic [2:0] PAUSE  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               shift_q, shift_d;
  logic               ctrl_q, ctrl_d;
  logic               alt_q, alt_d;
  logic               push_c;
  logic               push_ext_c;
  logic               push_rel_c;
  logic [7:0]         push_code_c;
  logic               pop_c;
  logic               full_c;
  logic               wr_c;
  logic [EW-1:0]      mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic               ovf_q;

  // Parser: one transition per received byte, plus modifier tracking on each emitted event
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ctrl_d      = ctrl_q;
    alt_d       = alt_q;
    push_c      = 1'b0;
    push_ext_c  = 1'b0;
    push_rel_c  = 1'b0;
    push_code_c = bus.rx_data;
    if (bus.rx_en) begin
      case (state_q)
        IDLE: begin
          case (bus.rx_data)
            8'hE0: state_d = EXT;
            8'hF0: state_d = BRK;
            8'hE1: begin
              state_d = PAUSE;
              cnt_d   = 3'd7;
            end
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_d = IDLE;
            default: push_c = 1'b1;
          endcase
        end
        EXT: begin
          if (bus.rx_data == 8'hF0) begin
            state_d = EXTBRK;
          end else begin
            state_d    = IDLE;
            // E0 12 is the fake shift wrapped around PrtScr
            push_c     = (bus.rx_data != 8'hE0) && (bus.rx_data != 8'hE1) &&
                         (bus.rx_data != 8'h12);
            push_ext_c = 1'b1;
          end
        end
        BRK: begin
          state_d    = IDLE;
          push_c     = 1'b1;
          push_rel_c = 1'b1;
        end
        EXTBRK: begin
          state_d    = IDLE;
          push_c     = (bus.rx_data != 8'h12);
          push_ext_c = 1'b1;
          push_rel_c = 1'b1;
        end
        PAUSE: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d     = IDLE;
            push_c      = 1'b1;
            push_code_c = 8'hE1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (push_c) begin
      if (!push_ext_c && (push_code_c == 8'h12 || push_code_c == 8'h59)) shift_d = !push_rel_c;
      if (push_code_c == 8'h14) ctrl_d = !push_rel_c;
      if (push_code_c == 8'h11) alt_d  = !push_rel_c;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      shift_q <= 1'b0;
      ctrl_q  <= 1'b0;
      alt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ctrl_q  <= ctrl_d;
      alt_q   <= alt_d;
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign pop_c  = (count_q != CW'(0)) && bus.ev_ready;
  assign full_c = (count_q == CW'(FIFO_DEPTH));
  assign wr_c   = push_c && (!full_c || pop_c);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_c) begin
        mem_q[wr_ptr_q] <= {push_ext_c, push_rel_c, push_code_c};
        wr_ptr_q        <= wr_ptr_q + FIFO_AW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      if (wr_c && !pop_c)      count_q <= count_q + CW'(1);
      else if (!wr_c && pop_c) count_q <= count_q - CW'(1);
      if (push_c && full_c && !pop_c) ovf_q <= 1'b1;
      else if (bus.ovf_clr)           ovf_q <= 1'b0;
    end
  end

  assign bus.ev_valid  = (count_q != CW'(0));
  assign bus.ev_ext    = mem_q[rd_ptr_q][9];
  assign bus.ev_rel    = mem_q[rd_ptr_q][8];
  assign bus.ev_code   = mem_q[rd_ptr_q][7:0];
  assign bus.ev_count  = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.mod_shift = shift_q;
  assign bus.mod_ctrl  = ctrl_q;
  assign bus.mod_alt   = alt_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: scan-code parsing, FIFO depth/overflow,
// simultaneous push/pop, modifiers and mid-sequence reset.
module tb_ps2_scancode_decoder;
  logic CLOCK_50;
  logic reset;
  int   passed;
  int   total;

  ps2_scancode_decoder_if #(.FIFO_AW(3)) bus ();

  ps2_scancode_decoder #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus.slave)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Present one byte for one clock; returns on the falling edge after capture
  task automatic send(input logic [7:0] b);
    @(negedge CLOCK_50);
    bus.rx_data = b;
    bus.rx_en   = 1'b1;
    @(negedge CLOCK_50);
    bus.rx_en   = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge CLOCK_50);
    bus.ev_ready = 1'b1;
    @(negedge CLOCK_50);
    bus.ev_ready = 1'b0;
  endtask

  task automatic clear_ovf();
    @(negedge CLOCK_50);
    bus.ovf_clr = 1'b1;
    @(negedge CLOCK_50);
    bus.ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (bus.ev_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.ev_valid); else passed++;
    total++; if (bus.ev_count !== 4'd0) $display("FAIL reset_count got %0d exp 0", bus.ev_count); else passed++;
    total++; if ({bus.ev_ext, bus.ev_rel, bus.ev_code} !== 10'h000)
      $display("FAIL reset_head got %b%b%h exp 0000", bus.ev_ext, bus.ev_rel, bus.ev_code); else passed++;
    total++; if ({bus.overflow, bus.mod_shift, bus.mod_ctrl, bus.mod_alt} !== 4'b0000)
      $display("FAIL reset_flags got %b exp 0000", {bus.overflow, bus.mod_shift, bus.mod_ctrl, bus.mod_alt}); else passed++;
  endtask

  task automatic test_make();
    send(8'h1C);
    total++; if (bus.ev_valid !== 1'b1) $display("FAIL make_valid got %b exp 1", bus.ev_valid); else passed++;
    total++; if ({bus.ev_ext, bus.ev_rel, bus.ev_code} !== {2'b00, 8'h1C})
      $display("FAIL make_event got %b%b%h exp 001c", bus.ev_ext, bus.ev_rel, bus.ev_code); else passed++;
    pop_one();
    total++; if (bus.ev_count !== 4'd0) $display("FAIL make_pop_count got %0d exp 0", bus.ev_count); else passed++;
    pop_one();
    total++; if (bus.ev_count !== 4'd0) $display("FAIL empty_pop_count got %0d exp 0", bus.ev_count); else passed++;
  endtask

  task automatic test_ext_break();
    send(8'hE0);
    total++; if (bus.ev_valid !== 1'b0) $display("FAIL ext_e0_valid got %b exp 0", bus.ev_valid); else passed++;
    send(8'hF0);
    total++; if (bus.ev_valid !== 1'b0) $display("FAIL ext_f0_valid got %b exp 0", bus.ev_valid); else passed++;
    send(8'h75);
    total++; if (bus.ev_count !== 4'd1) $display("FAIL extbrk_count got %0d exp 1", bus.ev_count); else passed++;
    total++; if ({bus.ev_ext, bus.ev_rel, bus.ev_code} !== {2'b11, 8'h75})
      $display("FAIL extbrk_event got %b%b%h exp 1175", bus.ev_ext, bus.ev_rel, bus.ev_code); else passed++;
    pop_one();
    send(8'hF0); send(8'h1C);
    total++; if ({bus.ev_ext, bus.ev_rel, bus.ev_code} !== {2'b01, 8'h1C})
      $display("FAIL brk_event got %b%b%h exp 011c", bus.ev_ext, bus.ev_rel, bus.ev_code); else passed++;
    pop_one();
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 7; i++) begin
      send(seq[i]);
      total++; if (bus.ev_count !== 4'd0) $display("FAIL pause_partial_%0d got %0d exp 0", i, bus.ev_count); else passed++;
    end
    send(seq[7]);
    total++; if (bus.ev_count !== 4'd1) $display("FAIL pause_count got %0d exp 1", bus.ev_count); else passed++;
    total++; if ({bus.ev_ext, bus.ev_rel, bus.ev_code} !== {2'b00, 8'hE1})
      $display("FAIL pause_event got %b%b%h exp 00e1", bus.ev_ext, bus.ev_rel, bus.ev_code); else passed++;
    pop_one();
    send(8'h1C);
    total++; if ({bus.ev_count, bus.ev_ext, bus.ev_rel, bus.ev_code} !== {4'd1, 2'b00, 8'h1C})
      $display("FAIL pause_idle_after got cnt %0d %b%b%h exp cnt 1 001c", bus.ev_count, bus.ev_ext, bus.ev_rel, bus.ev_code); else passed++;
    pop_one();
  endtask

  task automatic test_drops();
    send(8'hAA); send(8'hFA); send(8'h00);
    send(8'hE0); send(8'h12);
    send(8'hE0); send(8'hF0); send(8'h12);
    send(8'hE0); send(8'hE0);
    total++; if (bus.ev_count !== 4'd0) $display("FAIL drop_count got %0d exp 0", bus.ev_count); else passed++;
    total++; if (bus.mod_shift !== 1'b0) $display("FAIL fake_shift got %b exp 0", bus.mod_shift); else passed++;
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) send(8'(i));
    total++; if ({bus.ev_count, bus.overflow} !== {4'd8, 1'b0})
      $display("FAIL full_state got cnt %0d ovf %b exp cnt 8 ovf 0", bus.ev_count, bus.overflow); else passed++;
    send(8'h09);
    total++; if ({bus.ev_count, bus.overflow} !== {4'd8, 1'b1})
      $display("FAIL ovf_state got cnt %0d ovf %b exp cnt 8 ovf 1", bus.ev_count, bus.overflow); else passed++;
    total++; if (bus.ev_code !== 8'h01) $display("FAIL ovf_head got %h exp 01", bus.ev_code); else passed++;
    clear_ovf();
    total++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clr got %b exp 0", bus.overflow); else passed++;
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_codes [8];
    exp_codes = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    @(negedge CLOCK_50);
    bus.rx_data  = 8'h0A;
    bus.rx_en    = 1'b1;
    bus.ev_ready = 1'b1;
    @(negedge CLOCK_50);
    bus.rx_en    = 1'b0;
    bus.ev_ready = 1'b0;
    total++; if ({bus.ev_count, bus.overflow} !== {4'd8, 1'b0})
      $display("FAIL pushpop_state got cnt %0d ovf %b exp cnt 8 ovf 0", bus.ev_count, bus.overflow); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++; if (bus.ev_code !== exp_codes[i]) $display("FAIL drain_%0d got %h exp %h", i, bus.ev_code, exp_codes[i]); else passed++;
      pop_one();
    end
    total++; if (bus.ev_valid !== 1'b0) $display("FAIL drain_empty got %b exp 0", bus.ev_valid); else passed++;
  endtask

  task automatic test_modifiers();
    bus.ev_ready = 1'b1;
    send(8'h12);
    total++; if (bus.mod_shift !== 1'b1) $display("FAIL lshift_make got %b exp 1", bus.mod_shift); else passed++;
    send(8'hE0); send(8'h14);
    total++; if (bus.mod_ctrl !== 1'b1) $display("FAIL rctrl_make got %b exp 1", bus.mod_ctrl); else passed++;
    send(8'h11);
    total++; if (bus.mod_alt !== 1'b1) $display("FAIL lalt_make got %b exp 1", bus.mod_alt); else passed++;
    send(8'hF0); send(8'h12);
    total++; if ({bus.mod_shift, bus.mod_ctrl} !== 2'b01)
      $display("FAIL lshift_break got shift %b ctrl %b exp 0 1", bus.mod_shift, bus.mod_ctrl); else passed++;
    send(8'hE0); send(8'hF0); send(8'h14);
    total++; if (bus.mod_ctrl !== 1'b0) $display("FAIL rctrl_break got %b exp 0", bus.mod_ctrl); else passed++;
    send(8'h59);
    total++; if (bus.mod_shift !== 1'b1) $display("FAIL rshift_make got %b exp 1", bus.mod_shift); else passed++;
    @(negedge CLOCK_50);
    bus.ev_ready = 1'b0;
    total++; if (bus.ev_count !== 4'd0) $display("FAIL mod_drained got %0d exp 0", bus.ev_count); else passed++;
    for (int i = 0; i < 8; i++) send(8'h1C);
    send(8'hF0); send(8'h11);
    total++; if ({bus.mod_alt, bus.overflow, bus.ev_count} !== {1'b0, 1'b1, 4'd8})
      $display("FAIL alt_break_full got alt %b ovf %b cnt %0d exp 0 1 8", bus.mod_alt, bus.overflow, bus.ev_count); else passed++;
    clear_ovf();
    bus.ev_ready = 1'b1;
    repeat (8) @(negedge CLOCK_50);
    bus.ev_ready = 1'b0;
    total++; if (bus.ev_count !== 4'd0) $display("FAIL full_drain got %0d exp 0", bus.ev_count); else passed++;
  endtask

  task automatic test_reset_mid();
    send(8'hE0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    #5;
    total++; if ({bus.mod_shift, bus.ev_count} !== {1'b0, 4'd0})
      $display("FAIL async_reset got shift %b cnt %0d exp 0 0", bus.mod_shift, bus.ev_count); else passed++;
    reset = 1'b0;
    send(8'h1C);
    total++; if ({bus.ev_ext, bus.ev_rel, bus.ev_code} !== {2'b00, 8'h1C})
      $display("FAIL reset_mid_event got %b%b%h exp 001c", bus.ev_ext, bus.ev_rel, bus.ev_code); else passed++;
    pop_one();
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    reset        = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_en    = 1'b0;
    bus.ev_ready = 1'b0;
    bus.ovf_clr  = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    test_reset();
    reset = 1'b0;
    test_make();
    test_ext_break();
    test_pause();
    test_drops();
    test_overflow();
    test_push_pop_full();
    test_modifiers();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
